// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
// Provides the frame length, the baud divisor helper used by both the
// transmit queue and the transmitter (so the two divisors cannot diverge),
// and the state type of the transmit queue pacer.
package uart_pkg;

    // idle + start + 8 data + stop, matching the transmitter's shift register
    localparam int FRAME_BITS = 11;

    typedef enum logic {
        IDLE,
        WAIT
    } uart_txq_state_t;

    // Clock cycles per bit; integer division, truncating like the transmitter.
    function automatic int bit_cycles(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_queue_if.sv
// Handshake bundle between the CPU store path, the transmit queue and the
// UART transmitter.
//   push_i / data_i          : enqueue request and byte
//   full_o / empty_o         : occupancy flags
//   level_o                  : occupancy count, $clog2(DEPTH+1) bits
//   overflow_o               : sticky, a push was dropped
//   write_o / val_o          : one-cycle write strobe and byte to the transmitter
// master = producer / observer side, slave = the queue itself.
interface uart_tx_queue_if #(
    parameter int DEPTH = 16
);
    localparam int LEVEL_W = $clog2(DEPTH + 1);

    logic               push_i;
    logic [7:0]         data_i;
    logic               full_o;
    logic               empty_o;
    logic [LEVEL_W-1:0] level_o;
    logic               overflow_o;
    logic               write_o;
    logic [7:0]         val_o;

    modport master (
        output push_i, data_i,
        input  full_o, empty_o, level_o, overflow_o, write_o, val_o
    );

    modport slave (
        input  push_i, data_i,
        output full_o, empty_o, level_o, overflow_o, write_o, val_o
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock circular-buffer FIFO with a separate level counter.
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   push_i, data_i      : enqueue request and data
//   pop_i               : dequeue the head; caller only pops when non-empty
//   accept_o            : the push in this cycle is taken
//   head_o              : current head entry (combinational read)
//   full_o, empty_o     : occupancy flags
//   level_o             : current occupancy
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    output logic                         accept_o,
    output logic [WIDTH-1:0]             head_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LEVEL_W = $clog2(DEPTH + 1);
    localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(DEPTH);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LEVEL_W-1:0] level;

    // A pop in the same cycle frees the slot the push needs, even when full.
    assign accept_o = push_i && (!full_o || pop_i);
    assign head_o   = mem[rd_ptr];
    assign full_o   = (level == FULL_LEVEL);
    assign empty_o  = (level == '0);
    assign level_o  = level;

    // Storage is not reset; only entries below the level are ever read.
    always_ff @(posedge clk_i) begin
        if (!rst_i && accept_o) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (accept_o) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_i) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept_o, pop_i})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue and pacer feeding a UART transmitter that has no busy output.
// Bytes pushed by the CPU are buffered and handed to the transmitter one at
// a time, spaced a full frame apart so an in-flight frame is never overwritten.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset (shared with the transmitter)
//   bus          : slave side of uart_tx_queue_if (push/data in; flags, level,
//                  overflow, write strobe and byte out)
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int FREQ  = 27000000,
    parameter int BAUD  = 115200,
    parameter int DEPTH = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    uart_tx_queue_if.slave  bus
);
    localparam int BIT_CYCLES = bit_cycles(FREQ, BAUD);
    localparam int GAP_CYCLES = FRAME_BITS * BIT_CYCLES;
    localparam int CNT_W      = $clog2(GAP_CYCLES);

    generate
        if (GAP_CYCLES < 2) begin : g_gap_check
            $error("uart_tx_queue: GAP_CYCLES must be at least 2");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
            $error("uart_tx_queue: DEPTH must be a power of two, at least 2");
        end
    endgenerate

    uart_txq_state_t  state;
    logic [CNT_W-1:0] gap_cnt;
    logic             write_r;
    logic [7:0]       val_r;
    logic             overflow_r;

    logic             fifo_empty;
    logic             push_ok;
    logic [7:0]       head;
    logic             pop;

    // The head is popped on the very edge that raises write_o.
    assign pop = (state == IDLE) && !fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_i   (bus.push_i),
        .data_i   (bus.data_i),
        .pop_i    (pop),
        .accept_o (push_ok),
        .head_o   (head),
        .full_o   (bus.full_o),
        .empty_o  (fifo_empty),
        .level_o  (bus.level_o)
    );

    assign bus.empty_o    = fifo_empty;
    assign bus.write_o    = write_r;
    assign bus.val_o      = val_r;
    assign bus.overflow_o = overflow_r;

    // Pacer: issue a byte from IDLE, then sit in WAIT so that the next issue
    // lands exactly GAP_CYCLES edges later. The counter is loaded with
    // GAP_CYCLES-2 because the issue edge and the WAIT->IDLE edge each
    // account for one of the gap cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            gap_cnt    <= '0;
            write_r    <= 1'b0;
            val_r      <= '0;
            overflow_r <= 1'b0;
        end else begin
            write_r <= 1'b0;
            if (bus.push_i && !push_ok) begin
                overflow_r <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        write_r <= 1'b1;
                        val_r   <= head;
                        gap_cnt <= CNT_W'(GAP_CYCLES - 2);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
